// File: rtl/key_ctrl.sv
// Key sequencer for the digital clock: walks the time-setting mode FSM and turns
// debounced inc/dec key presses into single-cycle commands with long-press auto-repeat.
module key_ctrl #(
  parameter int unsigned LONG_CYC    = 50000000,
  parameter int unsigned REPEAT_CYC  = 10000000,
  parameter int unsigned TIMEOUT_CYC = 500000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_dec,
  output logic [1:0] set_sel,
  output logic       edit_active,
  output logic       inc_pulse,
  output logic       dec_pulse
);

  localparam int HOLD_W = $clog2(LONG_CYC) + 1;
  localparam int IDLE_W = $clog2(TIMEOUT_CYC) + 1;

  localparam logic [HOLD_W-1:0] HOLD_LONG   = HOLD_W'(LONG_CYC);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(LONG_CYC - REPEAT_CYC);
  localparam logic [IDLE_W-1:0] IDLE_LAST   = IDLE_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10,
    ST_SET_SEC = 2'b11
  } state_e;

  // Which key currently owns the hold counter and may auto-repeat.
  typedef enum logic [1:0] {
    ACT_NONE = 2'b00,
    ACT_INC  = 2'b01,
    ACT_DEC  = 2'b10
  } act_e;

  state_e            state_q, state_d;
  act_e              act_q, act_d;
  logic              mode_hist_q, inc_hist_q, dec_hist_q;
  logic              lock_q, lock_d;
  logic [HOLD_W-1:0] hold_q, hold_d, hold_next;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              edit_q, edit_d;
  logic              inc_pulse_q, inc_pulse_d;
  logic              dec_pulse_q, dec_pulse_d;

  logic mode_edge, inc_edge, dec_edge, any_key, both_keys, holding;

  assign mode_edge = key_mode & ~mode_hist_q;
  assign inc_edge  = key_inc  & ~inc_hist_q;
  assign dec_edge  = key_dec  & ~dec_hist_q;
  assign any_key   = key_mode | key_inc | key_dec;
  assign both_keys = key_inc & key_dec;
  assign holding   = ((act_q == ACT_INC) && key_inc) || ((act_q == ACT_DEC) && key_dec);
  assign hold_next = hold_q + HOLD_W'(1);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    act_d       = act_q;
    lock_d      = lock_q;
    hold_d      = hold_q;
    idle_d      = idle_q;
    inc_pulse_d = 1'b0;
    dec_pulse_d = 1'b0;

    if (both_keys)               lock_d = 1'b1;
    else if (!key_inc && !key_dec) lock_d = 1'b0;

    if (state_q == ST_NORMAL) begin
      act_d  = ACT_NONE;
      hold_d = '0;
      idle_d = '0;
      if (mode_edge) state_d = ST_SET_HR;
    end else if (idle_q == IDLE_LAST) begin
      state_d = ST_NORMAL;
      act_d   = ACT_NONE;
      hold_d  = '0;
      idle_d  = '0;
    end else if (mode_edge) begin
      // Mode wins over a coincident inc/dec edge; held keys lose ownership.
      state_d = state_e'(state_q + 2'd1);
      act_d   = ACT_NONE;
      hold_d  = '0;
      idle_d  = '0;
    end else begin
      idle_d = any_key ? '0 : idle_q + IDLE_W'(1);
      if (both_keys || lock_q) begin
        act_d  = ACT_NONE;
        hold_d = '0;
      end else if (inc_edge) begin
        inc_pulse_d = 1'b1;
        act_d       = ACT_INC;
        hold_d      = '0;
      end else if (dec_edge) begin
        dec_pulse_d = 1'b1;
        act_d       = ACT_DEC;
        hold_d      = '0;
      end else if (holding) begin
        if (hold_next == HOLD_LONG) begin
          inc_pulse_d = (act_q == ACT_INC);
          dec_pulse_d = (act_q == ACT_DEC);
          hold_d      = HOLD_RELOAD;
        end else begin
          hold_d = hold_next;
        end
      end else begin
        act_d  = ACT_NONE;
        hold_d = '0;
      end
    end

    edit_d = (state_d != ST_NORMAL);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q     <= ST_NORMAL;
      act_q       <= ACT_NONE;
      // History starts high so a key held through reset gives no press edge.
      mode_hist_q <= 1'b1;
      inc_hist_q  <= 1'b1;
      dec_hist_q  <= 1'b1;
      lock_q      <= 1'b0;
      hold_q      <= '0;
      idle_q      <= '0;
      edit_q      <= 1'b0;
      inc_pulse_q <= 1'b0;
      dec_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      mode_hist_q <= key_mode;
      inc_hist_q  <= key_inc;
      dec_hist_q  <= key_dec;
      lock_q      <= lock_d;
      hold_q      <= hold_d;
      idle_q      <= idle_d;
      edit_q      <= edit_d;
      inc_pulse_q <= inc_pulse_d;
      dec_pulse_q <= dec_pulse_d;
    end
  end

  assign set_sel     = state_q;
  assign edit_active = edit_q;
  assign inc_pulse   = inc_pulse_q;
  assign dec_pulse   = dec_pulse_q;

endmodule
